// File: rtl/seq_shifter_pkg.sv
//==== seq_shifter_pkg : shared op codes and FSM encodings | rev 1.0 ====
`default_nettype none

package seq_shifter_pkg;

  localparam int          DATA_W  = 32;
  localparam int          SHAMT_W = 5;

  localparam logic [1:0]  OP_SLL  = 2'b00;
  localparam logic [1:0]  OP_SRL  = 2'b01;
  localparam logic [1:0]  OP_RSVD = 2'b10;
  localparam logic [1:0]  OP_SRA  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Reserved code behaves as a logical right shift.
  function automatic logic is_right(input logic [1:0] op);
    return (op != OP_SLL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shifter_shift_step.sv
//==== shift_step : combinational one-bit shift by op kind | rev 1.0 ====
`default_nettype none

module shift_step
  import seq_shifter_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] shifted
);

  logic fill;

  always_comb begin
    fill    = (op == OP_SRA) ? value[DATA_W-1] : 1'b0;
    shifted = value;
    if (is_right(op)) begin
      shifted = {fill, value[DATA_W-1:1]};
    end else begin
      shifted = {value[DATA_W-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_shifter.sv
//==== seq_shifter : sequential shifter, one bit per cycle, IDLE/SHIFT/DONE FSM | rev 1.0 ====
`default_nettype none

module seq_shifter
  import seq_shifter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [DATA_W-1:0]   X,
  input  logic [SHAMT_W-1:0]  shamt,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   result
);

  state_t               state;
  state_t               state_next;
  logic [DATA_W-1:0]    work;
  logic [DATA_W-1:0]    work_step;
  logic [SHAMT_W-1:0]   count;
  logic [1:0]           op_q;
  logic [DATA_W-1:0]    result_q;

  shift_step u_shift_step (
    .value   (work),
    .op      (op_q),
    .shifted (work_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == SHAMT_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      count    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            work  <= X;
            count <= shamt;
            op_q  <= op;
          end
        end
        ST_SHIFT: begin
          work  <= work_step;
          count <= count - SHAMT_W'(1);
        end
        ST_DONE: begin
          result_q <= work;
        end
        default: begin
          work <= work;
        end
      endcase
    end
  end

  // The finished value is forwarded during DONE so result is valid alongside the done pulse.
  always_comb begin
    busy   = (state != ST_IDLE);
    done   = (state == ST_DONE);
    result = (state == ST_DONE) ? work : result_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_shifter.sv
//==== tb_seq_shifter : directed table-driven bench for seq_shifter | rev 1.0 ====
`default_nettype none

module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] X;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  seq_shifter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .X      (X),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] x;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                        input logic [4:0] s, input logic [31:0] exp);
    int lat;
    bit busy_ok;
    op = o; X = x; shamt = s; start = 1'b1;
    step();
    start = 1'b0;
    op = ~o; X = ~x; shamt = ~s;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(s) + 32'd1);
    check({nm, " result"}, result, exp);
    check({nm, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
    step();
    check({nm, " after"}, {30'd0, done, busy}, 32'd0);
    check({nm, " hold"}, result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int first_done;
    bit pat_ok;
    logic [31:0] seen;

    vecs[0] = '{"sll_1_4",      2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[1] = '{"sra_msb_31",   2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{"srl_msb_31",   2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[3] = '{"srl_zero_sh",  2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4] = '{"sra_neg_4",    2'b11, 32'hF000_0000, 5'd4,  32'hFF00_0000};
    vecs[5] = '{"sll_8",        2'b00, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00};
    vecs[6] = '{"rsvd_1",       2'b10, 32'h8000_0010, 5'd1,  32'h4000_0008};
    vecs[7] = '{"sll_31",       2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[8] = '{"sra_pos_3",    2'b11, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF};
    vecs[9] = '{"sra_zero_sh",  2'b11, 32'h8000_0000, 5'd0,  32'h8000_0000};

    rst = 1'b1; start = 1'b1; op = 2'b00; X = 32'h1234_5678; shamt = 5'd3;
    step(); step();
    check("reset state", {done, busy, 30'd0} | result, 32'd0);
    rst = 1'b0; start = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].sh, vecs[i].exp);
    end

    // start pulse while busy must be dropped
    op = 2'b01; X = 32'h0000_00F0; shamt = 5'd4; start = 1'b1;
    ndone = 0; first_done = -1; seen = '0;
    for (int k = 1; k <= 15; k++) begin
      step();
      start = (k == 2);
      if (k == 2) begin
        op = 2'b00; X = 32'hFFFF_FFFF; shamt = 5'd1;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          seen = result;
        end
      end
    end
    start = 1'b0;
    check("ignore done cycle", 32'(first_done), 32'd5);
    check("ignore done count", 32'(ndone), 32'd1);
    check("ignore result", seen, 32'h0000_000F);

    // reset sampled at accept+3 aborts the operation silently
    op = 2'b00; X = 32'h0000_0001; shamt = 5'd10; start = 1'b1;
    ndone = 0;
    step();
    start = 1'b0;
    if (done) ndone++;
    step();
    if (done) ndone++;
    rst = 1'b1;
    step();
    if (done) ndone++;
    check("rst abort state", {30'd0, done, busy}, 32'd0);
    check("rst abort result", result, 32'd0);
    check("rst abort no done", 32'(ndone), 32'd0);
    rst = 1'b0;
    run_op("after_rst", 2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C);

    // start held high: reserved op, one result every shamt+2 cycles
    op = 2'b10; X = 32'h0000_0004; shamt = 5'd1; start = 1'b1;
    pat_ok = 1'b1; ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (done !== ((k % 3) == 2)) pat_ok = 1'b0;
      if (done) begin
        ndone++;
        check("b2b result", result, 32'h0000_0002);
      end
    end
    start = 1'b0;
    check("b2b pattern", {31'd0, pat_ok}, 32'd1);
    check("b2b count", 32'(ndone), 32'd4);

    step(); step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL name them clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  2  shift kind: 00 SLL, 01 SRL, 11 SRA, 10 reserved (executes as SRL).
REQ-006 X  input  32  operand, captured on accept.
REQ-007 shamt  input  5  shift amount 0..31, captured on accept.
REQ-008 busy  output  1  high while an operation is in flight (SHIFT or DONE state).
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  32  last completed result; valid when done=1; held until next completion.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 Accept: IDLE with start=1 SHALL capture X, shamt and op into internal registers in that cycle.
REQ-013 On accept, the next state SHALL be DONE if shamt=0, otherwise SHIFT.
REQ-014 Each SHIFT cycle SHALL shift the working register by exactly one bit and decrement the remaining count by one.
REQ-015 SHIFT SHALL transition to DONE in the cycle the remaining count reaches 0.
REQ-016 SLL SHALL fill with 0 at bit 0. SRL SHALL fill with 0 at bit 31. SRA SHALL replicate bit 31 of the captured operand.
REQ-017 DONE SHALL assert done=1 for exactly one cycle, load result from the working register, and return to IDLE.
REQ-018 Latency SHALL be shamt+1 cycles from the accept edge to the done=1 cycle, for all shamt in 0..31.
REQ-019 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 Changes to X, shamt or op after accept SHALL NOT affect the in-flight operation.
REQ-022 start asserted in the cycle after done (IDLE) SHALL be accepted normally, giving back-to-back throughput of shamt+2 cycles per operation.
REQ-023 result SHALL be unchanged outside DONE cycles.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, and clear the working register and count to 0.
REQ-025 rst SHALL take priority over start and abort any in-flight operation with no done pulse.
REQ-026 The first start after rst deasserts SHALL be accepted in the same cycle.

Structure
REQ-027 Op-code constants (SLL/SRL/SRA/reserved) and FSM state encodings SHALL live in a shared package/include used by the decoder and ALU.
REQ-028 A single combinational sub-module shift_step SHALL compute the one-bit shift (inputs: 32-bit value, op; output: 32-bit value). The FSM, count and registers SHALL remain in seq_shifter.

Verification
REQ-029 SLL: X=0x0000_0001, shamt=4, op=00 -> done at accept+5, result=0x0000_0010, busy high for cycles 1..5.
REQ-030 SRA: X=0x8000_0000, shamt=31, op=11 -> done at accept+32, result=0xFFFF_FFFF; the same operand with op=01 gives result=0x0000_0001.
REQ-031 shamt=0: X=0xDEAD_BEEF, op=01 -> done at accept+1, result=0xDEAD_BEEF.
REQ-032 Ignore while busy: accept X=0x0000_00F0, shamt=4, SRL; pulse start with other data at accept+2 -> single done at accept+5, result=0x0000_000F, no second done.
REQ-033 Reset mid-op: rst at accept+3 of a shamt=10 op -> no done, busy=0, result=0; a new start the next cycle completes correctly.
REQ-034 Back-to-back and reserved op: start held high continuously, op=10, X=0x0000_0004, shamt=1 -> done every 3 cycles, result=0x0000_0002 each time.
